// File: rtl/bus_pkg.sv
// Shared bus constants, memory map and the checker state encoding.
package bus_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 256;

    localparam logic [ADDR_W-1:0] ROM_BASE = 16'h0000;
    localparam logic [ADDR_W-1:0] MEM_BASE = 16'h1000;
    localparam logic [ADDR_W-1:0] IO_BASE  = 16'hFF00;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        WAIT,
        CMP,
        DONE
    } chk_state_e;
endpackage

// File: rtl/masked_cmp.sv
// Masked inequality of two words; unknown masked bits report a mismatch.
module masked_cmp #(
    parameter int W = 256
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] mask_i,
    output logic         mismatch_o
);
    logic [W-1:0] diff;

    assign diff = (a_i ^ b_i) & mask_i;

    // Defaulting to 1 makes an X/Z difference fall through as a mismatch.
    always_comb begin
        mismatch_o = 1'b1;
        if (diff == '0) mismatch_o = 1'b0;
    end
endmodule

// File: rtl/bus_mem_checker.sv
// Bus initiator that reads main memory after the program stops and checks
// each location against an expected value/mask pair.
module bus_mem_checker
    import bus_pkg::*;
#(
    parameter int                           DATA_W   = bus_pkg::DATA_W,
    parameter int                           ADDR_W   = bus_pkg::ADDR_W,
    parameter logic [bus_pkg::ADDR_W-1:0]   MEM_BASE = bus_pkg::MEM_BASE,
    parameter int                           NUM_LOCS = 12,
    parameter int                           READ_LAT = 1
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              start,
    input  logic              bus_gnt,
    input  logic [DATA_W-1:0] MemDataIn,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [DATA_W-1:0] exp_mask,
    output logic              bus_req,
    output logic [ADDR_W-1:0] address,
    output logic              nRead,
    output logic              nWrite,
    output logic [3:0]        exp_index,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       fail_mask,
    output logic [4:0]        fail_count
);
    chk_state_e        state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [1:0]        lat_q, lat_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       fmask_q, fmask_d;
    logic [4:0]        fcnt_q, fcnt_d;
    logic              mismatch;
    logic              reading;

    masked_cmp #(.W(DATA_W)) u_cmp (
        .a_i        (data_q),
        .b_i        (exp_data),
        .mask_i     (exp_mask),
        .mismatch_o (mismatch)
    );

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lat_q   <= '0;
            data_q  <= '0;
            fmask_q <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
            fmask_q <= fmask_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        data_d  = data_q;
        fmask_d = fmask_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = REQ;
                    idx_d   = '0;
                    fmask_d = '0;
                    fcnt_d  = '0;
                end
            end
            REQ: if (bus_gnt) state_d = ADDR;
            ADDR: begin
                if (!bus_gnt) begin
                    state_d = REQ;
                end else begin
                    lat_d   = 2'(READ_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Losing the grant discards the read; the same location is retried.
                if (!bus_gnt) begin
                    state_d = REQ;
                end else if (lat_q == '0) begin
                    data_d  = MemDataIn;
                    state_d = CMP;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            CMP: begin
                if (mismatch) begin
                    fmask_d[idx_q] = 1'b1;
                    fcnt_d         = fcnt_q + 5'd1;
                end
                if (idx_q == 4'(NUM_LOCS - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ADDR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign reading    = (state_q == ADDR) || (state_q == WAIT);
    assign bus_req    = reading || (state_q == REQ) || (state_q == CMP);
    assign nRead      = !reading;
    assign nWrite     = 1'b1;
    assign address    = reading ? (MEM_BASE + ADDR_W'(idx_q)) : '0;
    assign exp_index  = idx_q;
    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign done       = (state_q == DONE);
    assign pass       = (state_q == DONE) && (fcnt_q == '0);
    assign fail_mask  = fmask_q;
    assign fail_count = fcnt_q;
endmodule

// File: doc/bus_mem_checker.md
Name: bus_mem_checker

Overview:
- Bus initiator that takes the shared memory bus after the program stops, reads main-memory locations 0..NUM_LOCS-1 in order, and compares each read against an expected value/mask pair.
- Sits beside Execution on the Clk/address/nRead/nWrite bus. The top-level mux selects its address and strobes while it holds the bus.
- Reports pass/fail, a per-location failure mask and a failure count. It replaces passive hierarchical peeking with a real bus-level check.

Parameters:
- DATA_W, 256, bus data width.
- ADDR_W, 16, bus address width.
- MEM_BASE, 16'h1000, main-memory base address; location i is read at MEM_BASE+i.
- NUM_LOCS, 12, number of locations checked (1..16).
- READ_LAT, 1, cycles from the first Clk edge with nRead low to valid MemDataIn (1..4).

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- nReset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a check run.
- bus_gnt  in  1  bus grant from the top-level arbiter/mux.
- MemDataIn  in  DATA_W  MainMemory read data.
- exp_data  in  DATA_W  expected value for exp_index (combinational lookup outside the block).
- exp_mask  in  DATA_W  compare mask for exp_index; 1 = bit checked.
- bus_req  out  1  bus request.
- address  out  ADDR_W  bus address; valid only while bus_gnt=1.
- nRead  out  1  active-low read strobe.
- nWrite  out  1  active-low write strobe; the block never writes.
- exp_index  out  4  location currently being read or compared.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start or reset.
- pass  out  1  valid while done=1; 1 means no mismatches.
- fail_mask  out  16  bit i set when location i mismatched.
- fail_count  out  5  number of mismatching locations.

Behaviour:
- Reset (nReset=0 at a Clk edge): state=IDLE.
  - bus_req=0, nRead=1, nWrite=1, address=0.
  - exp_index=0, busy=0, done=0, pass=0.
  - fail_mask=0, fail_count=0.
  - Reset mid-run aborts immediately; bus strobes are released in the same edge.
- nWrite is held at 1 at all times.
- IDLE:
  - start=1 → REQ. On entry: clear fail_mask, fail_count, done, pass; exp_index=0; busy=1; bus_req=1.
- REQ:
  - bus_req=1, nRead=1.
  - bus_gnt=1 → ADDR.
- ADDR:
  - Drive address=MEM_BASE+exp_index and nRead=0.
  - Load the latency counter with READ_LAT-1 → WAIT.
- WAIT:
  - Hold address and nRead=0.
  - Decrement the counter each cycle.
  - When the counter is 0, sample MemDataIn and go to CMP. Total nRead-low time is READ_LAT+1 cycles.
- CMP:
  - nRead=1.
  - mismatch = |((MemDataIn ^ exp_data) & exp_mask). An X/Z in a masked bit counts as a mismatch.
  - On mismatch: set fail_mask[exp_index] and increment fail_count.
  - If exp_index==NUM_LOCS-1 → DONE. Otherwise increment exp_index → ADDR (bus is retained; bus_req stays 1).
- DONE:
  - bus_req=0, busy=0, done=1, pass=(fail_count==0); address returns to 0.
  - start=1 → behaves as from IDLE (clears results, new run).
- bus_gnt falling in ADDR or WAIT:
  - Abort the current read; nRead=1 in the next cycle.
  - Go to REQ with the same exp_index. No compare is done and no result is updated.
- start while busy=1 is ignored.
- exp_mask=0 always compares equal.
- Location index never exceeds NUM_LOCS-1; there is no wrap.
- Run latency with grant held: 1 (REQ) + NUM_LOCS×(READ_LAT+2) cycles from start to done.

Decomposition:
- Shared package bus_pkg holds:
  - ADDR_W and DATA_W constants
  - MEM_BASE and the other region base constants
  - typedef enum for checker states {IDLE, REQ, ADDR, WAIT, CMP, DONE}
- Sub-module masked_cmp: combinational masked equality of DATA_W-wide operands, with a 1-bit mismatch output.
- FSM, counters and result registers stay in bus_mem_checker.

Test Plan:
- All-match run:
  - Stimulus: memory model returns the location index as data, exp_data = index, exp_mask all-ones, NUM_LOCS=12, READ_LAT=1, bus_gnt tied 1, start pulse.
  - Response: done after 1+12×3=37 cycles; pass=1; fail_mask=0; fail_count=0; addresses 1000..100B seen in order.
- Masked compare:
  - Stimulus: location 10 returns 256'h…FFFF_0024; exp_data low 16 bits = 16'h0024; exp_mask = 16'hFFFF in the low bits only.
  - Response: no failure for location 10.
- Two mismatches:
  - Stimulus: locations 2 and 7 return wrong data.
  - Response: fail_mask=16'h0084; fail_count=2; pass=0.
- Grant loss:
  - Stimulus: bus_gnt dropped for 3 cycles during WAIT of location 5.
  - Response: nRead=1 next cycle; bus_req stays 1; location 5 is re-read after regrant; final results are as in the all-match run; fail_count is unchanged by the abort.
- Reset mid-run:
  - Stimulus: nReset=0 for 1 cycle at location 4.
  - Response: at the next edge all outputs are at reset values (bus_req=0, nRead=1, busy=0, fail_mask=0); a later start restarts from location 0.
- Restart and latency:
  - Stimulus: start pulsed while busy, then again in DONE, with READ_LAT=3.
  - Response: the start while busy is ignored; the start in DONE clears results; nRead is low for 4 cycles per location; done comes 1+12×5=61 cycles after start.
